multicycle_ctrl: RTL and testbench

- Main control FSM for the multicycle RV64 datapath.
- Sequences fetch, decode, execute, memory and writeback for each instruction.
- Drives the write-data source select of the register-file writeback mux, plus the ALU, PC, memory and register-file enables.
- Sits beside the datapath and reads the latched instruction register and the ALU zero flag.

---
 rtl/ctrl_pkg.sv | 82 ++++++++
 rtl/ctrl_decode.sv | 129 ++++++++++++
 rtl/multicycle_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the multicycle RV64 control unit.
//   state_t       - main FSM states
//   iclass_t      - instruction class produced by ctrl_decode
//   ds_sel_t      - writeback mux source select (also used by the datapath mux)
//   alu_op_t, shift_op_t, pc_src_t, alu_src_b_t - datapath control encodings
//   OP_*          - RV64 major opcodes recognised by the controller
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_WB,
        S_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_BRANCH,
        S_LUI,
        S_JAL,
        S_JALR,
        S_ILLEGAL
    } state_t;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_I,
        CLS_LD,
        CLS_SD,
        CLS_BR,
        CLS_LUI,
        CLS_JAL,
        CLS_JALR,
        CLS_BAD
    } iclass_t;

    typedef enum logic [2:0] {
        DS_ALU   = 3'b000,
        DS_LUI   = 3'b001,
        DS_MDR   = 3'b010,
        DS_SLT   = 3'b011,
        DS_SHIFT = 3'b100,
        DS_PC    = 3'b101
    } ds_sel_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100
    } alu_op_t;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10
    } shift_op_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_TARGET = 2'b01,
        PC_JALR   = 2'b10
    } pc_src_t;

    typedef enum logic [1:0] {
        SRCB_REG  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational instruction classifier for multicycle_ctrl.
//   instr    in  32  latched instruction register
//   iclass   out     instruction class used for dispatch out of DECODE
//   alu_op   out     ALU operation for EXEC_R / EXEC_I
//   shift_op out     shifter operation for immediate shifts
//   ds_sel   out     writeback source for this instruction
//   legal    out     instruction is supported (R/I-type legality is acted on
//                    in the EXEC states, everything else at DECODE)
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output iclass_t     iclass,
    output alu_op_t     alu_op,
    output shift_op_t   shift_op,
    output ds_sel_t     ds_sel,
    output logic        legal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    // Register/immediate fields are consumed by the datapath, not here.
    assign unused_fields = ^instr[24:15] ^ ^instr[11:7];

    always_comb begin
        iclass   = CLS_BAD;
        alu_op   = ALU_ADD;
        shift_op = SH_SLL;
        ds_sel   = DS_ALU;
        legal    = 1'b0;
        case (opcode)
            OP_R: begin
                // Class is R even when the funct fields are unsupported, so
                // the illegal decision lands in EXEC_R.
                iclass = CLS_R;
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000) begin
                            legal  = 1'b1;
                            alu_op = ALU_ADD;
                        end else if (funct7 == 7'b0100000) begin
                            legal  = 1'b1;
                            alu_op = ALU_SUB;
                        end
                    end
                    3'b010: begin
                        legal  = (funct7 == 7'b0000000);
                        alu_op = ALU_SLT;
                        ds_sel = DS_SLT;
                    end
                    3'b111: begin
                        legal  = (funct7 == 7'b0000000);
                        alu_op = ALU_AND;
                    end
                    3'b110: begin
                        legal  = (funct7 == 7'b0000000);
                        alu_op = ALU_OR;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_I: begin
                iclass = CLS_I;
                case (funct3)
                    3'b000: legal = 1'b1;
                    3'b010: begin
                        legal  = 1'b1;
                        alu_op = ALU_SLT;
                        ds_sel = DS_SLT;
                    end
                    3'b001: begin
                        legal    = 1'b1;
                        shift_op = SH_SLL;
                        ds_sel   = DS_SHIFT;
                    end
                    3'b101: begin
                        legal    = 1'b1;
                        shift_op = instr[30] ? SH_SRA : SH_SRL;
                        ds_sel   = DS_SHIFT;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_LOAD: begin
                if (funct3 == 3'b011) begin
                    iclass = CLS_LD;
                    ds_sel = DS_MDR;
                    legal  = 1'b1;
                end
            end
            OP_STORE: begin
                if (funct3 == 3'b011) begin
                    iclass = CLS_SD;
                    legal  = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    iclass = CLS_BR;
                    alu_op = ALU_SUB;
                    legal  = 1'b1;
                end
            end
            OP_LUI: begin
                iclass = CLS_LUI;
                ds_sel = DS_LUI;
                legal  = 1'b1;
            end
            OP_JAL: begin
                iclass = CLS_JAL;
                ds_sel = DS_PC;
                legal  = 1'b1;
            end
            OP_JALR: begin
                iclass = CLS_JALR;
                ds_sel = DS_PC;
                legal  = 1'b1;
            end
            default: iclass = CLS_BAD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multicycle RV64 datapath.
// Sequences fetch/decode/execute/memory/writeback; all outputs are Moore
// outputs decoded from the state register plus the latched instr fields.
//   clk, reset   clock, asynchronous active-high reset
//   instr        instruction register (valid from DECODE onward)
//   zero         ALU zero flag (branch condition)
//   mem_read/mem_write, ir_write, mdr_write, pc_write, reg_write  enables
//   pc_src, alu_src_b, alu_op, shift_op, ds_sel                   selects
//   instr_done   pulse on the last cycle of every instruction
//   illegal      high while parked in ILLEGAL
//   state_dbg    current FSM state for observation
// MEM_LAT: memory latency in cycles, legal range 1..15.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mdr_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic [1:0]  shift_op,
    output logic        reg_write,
    output logic [2:0]  ds_sel,
    output logic        instr_done,
    output logic        illegal,
    output state_t      state_dbg
);

    localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

    state_t    state, state_next;
    logic [3:0] cnt, cnt_next;
    logic       cnt_last;
    logic       rd_nz;

    iclass_t   dec_class;
    alu_op_t   dec_alu_op;
    shift_op_t dec_shift_op;
    ds_sel_t   dec_ds_sel;
    logic      dec_legal;

    ctrl_decode u_decode (
        .instr    (instr),
        .iclass   (dec_class),
        .alu_op   (dec_alu_op),
        .shift_op (dec_shift_op),
        .ds_sel   (dec_ds_sel),
        .legal    (dec_legal)
    );

    assign cnt_last  = (cnt == LAST);
    // Writes to x0 are suppressed here so the register file needs no guard.
    assign rd_nz     = (instr[11:7] != 5'd0);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RST;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mdr_write  = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_PLUS4;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        shift_op   = SH_SLL;
        reg_write  = 1'b0;
        ds_sel     = DS_ALU;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_RST: state_next = S_FETCH;
            S_FETCH: begin
                mem_read = 1'b1;
                if (cnt_last) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    pc_src     = PC_PLUS4;
                    state_next = S_DECODE;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed while the opcode is dispatched.
                alu_src_b = SRCB_IMM;
                case (dec_class)
                    CLS_R:    state_next = S_EXEC_R;
                    CLS_I:    state_next = S_EXEC_I;
                    CLS_LD,
                    CLS_SD:   state_next = S_ADDR;
                    CLS_BR:   state_next = S_BRANCH;
                    CLS_LUI:  state_next = S_LUI;
                    CLS_JAL:  state_next = S_JAL;
                    CLS_JALR: state_next = S_JALR;
                    default:  state_next = S_ILLEGAL;
                endcase
            end
            S_EXEC_R: begin
                alu_src_b  = SRCB_REG;
                alu_op     = dec_alu_op;
                state_next = dec_legal ? S_WB : S_ILLEGAL;
            end
            S_EXEC_I: begin
                alu_src_b  = SRCB_IMM;
                alu_op     = dec_alu_op;
                shift_op   = dec_shift_op;
                state_next = dec_legal ? S_WB : S_ILLEGAL;
            end
            S_WB: begin
                reg_write  = rd_nz;
                ds_sel     = dec_ds_sel;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_ADDR: begin
                alu_src_b  = SRCB_IMM;
                alu_op     = ALU_ADD;
                state_next = (dec_class == CLS_LD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                if (cnt_last) begin
                    mdr_write  = 1'b1;
                    state_next = S_WB;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                if (cnt_last) begin
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            S_BRANCH: begin
                alu_op     = ALU_SUB;
                pc_src     = PC_TARGET;
                // funct3[0] distinguishes bne from beq.
                pc_write   = instr[12] ? ~zero : zero;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_LUI: begin
                reg_write  = rd_nz;
                ds_sel     = DS_LUI;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL, S_JALR: begin
                reg_write  = rd_nz;
                ds_sel     = DS_PC;
                pc_write   = 1'b1;
                pc_src     = (state == S_JAL) ? PC_TARGET : PC_JALR;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_ILLEGAL: illegal = 1'b1;
            default:   state_next = S_RST;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed + randomized check of multicycle_ctrl at
// MEM_LAT = 2. Each instruction is expanded, by mnemonic, into its expected
// per-cycle output timeline (with a care mask for the fields that matter in
// that cycle); the timeline is then replayed against the DUT.
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
    logic        mem_read, mem_write, ir_write, mdr_write, pc_write;
    logic [1:0]  pc_src, alu_src_b, shift_op;
    logic [2:0]  alu_op, ds_sel;
    logic        reg_write, instr_done, illegal;
    state_t      state_dbg;

    multicycle_ctrl #(.MEM_LAT(L)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .zero       (zero),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .mdr_write  (mdr_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .shift_op   (shift_op),
        .reg_write  (reg_write),
        .ds_sel     (ds_sel),
        .instr_done (instr_done),
        .illegal    (illegal),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mdr_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] shift_op;
        logic       reg_write;
        logic [2:0] ds_sel;
        logic       instr_done;
        logic       illegal;
    } ov_t;

    typedef enum int {
        O_ADD, O_SUB, O_SLT, O_AND, O_OR, O_ADDI, O_SLTI, O_SLLI, O_SRLI,
        O_SRAI, O_LD, O_SD, O_BEQ, O_BNE, O_LUI, O_JAL, O_JALR, O_BADR, O_BADOP
    } op_e;

    // ---------------- scoreboard ----------------
    logic [19:0] exp_q[$];
    logic [19:0] msk_q[$];
    logic [31:0] ins_q[$];
    logic        zro_q[$];
    string       tag_q[$];
    int          total = 0;
    int          bad = 0;

    function automatic ov_t observe();
        ov_t o;
        o.mem_read   = mem_read;
        o.mem_write  = mem_write;
        o.ir_write   = ir_write;
        o.mdr_write  = mdr_write;
        o.pc_write   = pc_write;
        o.pc_src     = pc_src;
        o.alu_src_b  = alu_src_b;
        o.alu_op     = alu_op;
        o.shift_op   = shift_op;
        o.reg_write  = reg_write;
        o.ds_sel     = ds_sel;
        o.instr_done = instr_done;
        o.illegal    = illegal;
        return o;
    endfunction

    // Every enable and the illegal flag are checked in every cycle.
    function automatic ov_t base_mask();
        ov_t m;
        m = '0;
        m.mem_read = 1'b1; m.mem_write = 1'b1; m.ir_write = 1'b1;
        m.mdr_write = 1'b1; m.pc_write = 1'b1; m.reg_write = 1'b1;
        m.instr_done = 1'b1; m.illegal = 1'b1;
        return m;
    endfunction

    task automatic check(input string tag, input logic [19:0] ev, input logic [19:0] mv);
        logic [19:0] ov;
        ov = observe();
        total++;
        assert ((ov & mv) === (ev & mv)) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h care=%h", tag, ov & mv, ev & mv, mv);
        end
    endtask

    task automatic push(input string tag, input ov_t e, input ov_t m,
                        input logic [31:0] ins, input logic z);
        exp_q.push_back(e);
        msk_q.push_back(m);
        ins_q.push_back(ins);
        zro_q.push_back(z);
        tag_q.push_back(tag);
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [31:0] enc(input op_e op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [31:0] imm);
        case (op)
            O_ADD:  return {7'h00, rs2, rs1, 3'b000, rd, 7'b0110011};
            O_SUB:  return {7'h20, rs2, rs1, 3'b000, rd, 7'b0110011};
            O_SLT:  return {7'h00, rs2, rs1, 3'b010, rd, 7'b0110011};
            O_AND:  return {7'h00, rs2, rs1, 3'b111, rd, 7'b0110011};
            O_OR:   return {7'h00, rs2, rs1, 3'b110, rd, 7'b0110011};
            O_ADDI: return {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
            O_SLTI: return {imm[11:0], rs1, 3'b010, rd, 7'b0010011};
            O_SLLI: return {6'b000000, imm[5:0], rs1, 3'b001, rd, 7'b0010011};
            O_SRLI: return {6'b000000, imm[5:0], rs1, 3'b101, rd, 7'b0010011};
            O_SRAI: return {6'b010000, imm[5:0], rs1, 3'b101, rd, 7'b0010011};
            O_LD:   return {imm[11:0], rs1, 3'b011, rd, 7'b0000011};
            O_SD:   return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
            O_BEQ:  return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
            O_BNE:  return {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011};
            O_LUI:  return {imm[31:12], rd, 7'b0110111};
            O_JAL:  return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            O_JALR: return {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
            O_BADR: return {7'h00, rs2, rs1, 3'b001, rd, 7'b0110011};
            default: return 32'h0000007F;
        endcase
    endfunction

    task automatic push_wb(input string nm, input logic [31:0] ins, input logic wr,
                           input logic [2:0] ds);
        ov_t e, m;
        e = '0; m = base_mask();
        e.reg_write = wr; e.instr_done = 1'b1; e.ds_sel = ds; m.ds_sel = '1;
        push({nm, ".wb"}, e, m, ins, rnd_bit());
    endtask

    task automatic push_mem(input string nm, input logic [31:0] ins, input logic is_rd);
        ov_t e, m;
        e = '0; m = base_mask();
        e.alu_src_b = 2'b01; m.alu_src_b = '1; e.alu_op = 3'b000; m.alu_op = '1;
        push({nm, ".addr"}, e, m, ins, rnd_bit());
        for (int c = 0; c < L; c++) begin
            e = '0; m = base_mask();
            if (is_rd) begin
                e.mem_read = 1'b1; e.mdr_write = (c == L - 1);
            end else begin
                e.mem_write = 1'b1; e.instr_done = (c == L - 1);
            end
            push({nm, ".mem"}, e, m, ins, rnd_bit());
        end
    endtask

    // Expected timeline of one instruction, built from its mnemonic.
    task automatic push_instr(input op_e op, input logic [31:0] ins, input logic z);
        ov_t   e, m;
        logic  wr;
        string nm;
        nm = op.name();
        wr = (ins[11:7] != 5'd0);
        for (int c = 0; c < L; c++) begin
            e = '0; m = base_mask();
            e.mem_read = 1'b1;
            if (c == L - 1) begin
                e.ir_write = 1'b1; e.pc_write = 1'b1; e.pc_src = 2'b00; m.pc_src = '1;
            end
            // instr is not yet meaningful during fetch: drive junk.
            push({nm, ".fetch"}, e, m, $urandom, rnd_bit());
        end
        e = '0; m = base_mask();
        e.alu_src_b = 2'b01; m.alu_src_b = '1;
        push({nm, ".decode"}, e, m, ins, rnd_bit());
        e = '0; m = base_mask();
        case (op)
            O_ADD, O_SUB, O_SLT, O_AND, O_OR: begin
                m.alu_op = '1;
                e.alu_op = (op == O_ADD) ? 3'b000 : (op == O_SUB) ? 3'b001 :
                           (op == O_AND) ? 3'b010 : (op == O_OR)  ? 3'b011 : 3'b100;
                push({nm, ".exec"}, e, m, ins, rnd_bit());
                push_wb(nm, ins, wr, (op == O_SLT) ? 3'b011 : 3'b000);
            end
            O_ADDI, O_SLTI: begin
                e.alu_src_b = 2'b01; m.alu_src_b = '1;
                e.alu_op = (op == O_ADDI) ? 3'b000 : 3'b100; m.alu_op = '1;
                push({nm, ".exec"}, e, m, ins, rnd_bit());
                push_wb(nm, ins, wr, (op == O_ADDI) ? 3'b000 : 3'b011);
            end
            O_SLLI, O_SRLI, O_SRAI: begin
                e.alu_src_b = 2'b01; m.alu_src_b = '1;
                e.shift_op = (op == O_SLLI) ? 2'b00 : (op == O_SRLI) ? 2'b01 : 2'b10;
                m.shift_op = '1;
                push({nm, ".exec"}, e, m, ins, rnd_bit());
                push_wb(nm, ins, wr, 3'b100);
            end
            O_LD: begin
                push_mem(nm, ins, 1'b1);
                push_wb(nm, ins, wr, 3'b010);
            end
            O_SD: push_mem(nm, ins, 1'b0);
            O_BEQ, O_BNE: begin
                e.alu_op = 3'b001; m.alu_op = '1;
                e.pc_src = 2'b01; m.pc_src = '1;
                e.pc_write = (op == O_BEQ) ? z : !z;
                e.instr_done = 1'b1;
                push({nm, ".branch"}, e, m, ins, z);
            end
            O_LUI: begin
                e.reg_write = wr; e.ds_sel = 3'b001; m.ds_sel = '1; e.instr_done = 1'b1;
                push({nm, ".lui"}, e, m, ins, rnd_bit());
            end
            O_JAL, O_JALR: begin
                e.reg_write = wr; e.ds_sel = 3'b101; m.ds_sel = '1;
                e.pc_write = 1'b1; e.pc_src = (op == O_JAL) ? 2'b01 : 2'b10; m.pc_src = '1;
                e.instr_done = 1'b1;
                push({nm, ".jump"}, e, m, ins, rnd_bit());
            end
            O_BADR: push({nm, ".exec"}, e, m, ins, rnd_bit());
            default: ;
        endcase
    endtask

    task automatic push_illegal(input int n, input logic [31:0] ins);
        ov_t e, m;
        for (int i = 0; i < n; i++) begin
            e = '0; m = base_mask(); e.illegal = 1'b1;
            push("illegal", e, m, ins, rnd_bit());
        end
    endtask

    task automatic push_rst();
        push("rst_cycle", '0, '1, $urandom, rnd_bit());
    endtask

    // ---------------- driver ----------------
    // Entered just after a rising edge; inputs for the cycle are driven,
    // outputs are sampled on the falling edge.
    task automatic run_q();
        while (exp_q.size() > 0) begin
            logic [19:0] ev, mv;
            string       t;
            instr = ins_q.pop_front();
            zero  = zro_q.pop_front();
            ev    = exp_q.pop_front();
            mv    = msk_q.pop_front();
            t     = tag_q.pop_front();
            @(negedge clk);
            check(t, ev, mv);
            @(posedge clk);
            #1;
        end
    endtask

    // Asserts reset asynchronously mid-cycle, checks outputs drop at once,
    // then releases it so the following cycle is the RST cycle.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check(tag, '0, '1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        push_rst();
    endtask

    initial begin
        op_e         op;
        logic [4:0]  rd;
        logic [31:0] ins;
        ov_t         e, m;

        reset = 1'b1;
        instr = '0;
        zero  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", '0, '1);
        reset = 1'b0;
        push_rst();

        // Directed instructions.
        push_instr(O_ADD,  32'h002082B3, 1'b0);
        push_instr(O_LD,   32'h0080B183, 1'b0);
        push_instr(O_BEQ,  enc(O_BEQ, 5'd0, 5'd1, 5'd2, 32'd16), 1'b1);
        push_instr(O_BEQ,  enc(O_BEQ, 5'd0, 5'd1, 5'd2, 32'd16), 1'b0);
        push_instr(O_BNE,  enc(O_BNE, 5'd0, 5'd3, 5'd4, 32'd8), 1'b1);
        push_instr(O_BNE,  enc(O_BNE, 5'd0, 5'd3, 5'd4, 32'd8), 1'b0);
        push_instr(O_JAL,  32'h010000EF, 1'b0);
        push_instr(O_SLTI, 32'h00A02013, 1'b0);
        push_instr(O_LUI,  32'h123453B7, 1'b0);
        push_instr(O_SD,   enc(O_SD, 5'd0, 5'd1, 5'd2, 32'd24), 1'b0);
        push_instr(O_JALR, enc(O_JALR, 5'd0, 5'd6, 5'd0, 32'd4), 1'b0);
        run_q();

        // Randomized legal instruction stream.
        repeat (60) begin
            op  = op_e'($urandom_range(0, 16));
            rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ins = enc(op, rd, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), $urandom);
            push_instr(op, ins, rnd_bit());
        end
        run_q();

        // Unsupported R-type combination: caught in EXEC_R, then absorbing.
        ins = enc(O_BADR, 5'd5, 5'd1, 5'd2, 32'd0);
        push_instr(O_BADR, ins, 1'b0);
        push_illegal(8, ins);
        run_q();
        do_reset("reset_from_illegal_r");

        // Unknown opcode: stays in ILLEGAL for 20 cycles with enables off.
        push_instr(O_BADOP, 32'h0000007F, 1'b0);
        push_illegal(20, 32'h0000007F);
        run_q();
        do_reset("reset_from_illegal");

        // Reset on the last FETCH count must win over ir_write/pc_write,
        // and FETCH must restart from its first count afterwards.
        e = '0; m = base_mask(); e.mem_read = 1'b1;
        push("fetch_first", e, m, $urandom, 1'b0);
        run_q();
        e = '0; m = base_mask();
        e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        check("fetch_last_before_reset", e, m);
        do_reset("reset_mid_fetch");
        push_instr(O_ADD, 32'h002082B3, 1'b0);
        run_q();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
